// File: rtl/cmd_tx_queue.sv
// cmd_tx_queue: turns edges on raw switch/button levels into command bytes,
// queues them in a small FIFO and presents the head byte to a UART transmitter.
// A pending flag per (channel, edge) pair absorbs events while the FIFO is busy.
module cmd_tx_queue #(
    parameter int                  N_CH     = 4,
    parameter int                  DEPTH    = 8,
    parameter logic [8*N_CH-1:0]   RISE_CMD = {8'h00, 8'h00, 8'h00, 8'h05},
    parameter logic [8*N_CH-1:0]   FALL_CMD = {8'h00, 8'h00, 8'h00, 8'h09}
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         req_in,
    input  logic                    enable,
    input  logic                    flush,
    output logic [7:0]              tx_bits,
    input  logic                    tx_ready,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [2*N_CH-1:0]       pending,
    output logic [7:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int NB = 2 * N_CH;
    localparam int IW = $clog2(NB);

    // Saturating add of a small per-cycle increment onto the 8-bit drop counter.
    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [4:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {4'b0000, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Registered state
    logic [N_CH-1:0] s1_r;
    logic [N_CH-1:0] s2_r;
    logic [N_CH-1:0] s3_r;
    logic [1:0]      sup_cnt_r;
    logic [NB-1:0]   pending_r;
    logic [7:0]      drop_cnt_r;
    logic [7:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [7:0]      tx_bits_r;

    // Combinational helpers
    logic [7:0]      cmd_s [NB];
    logic            armed_s;
    logic [NB-1:0]   edge_s;
    logic [NB-1:0]   event_s;
    logic [NB-1:0]   grant_s;
    logic            found_s;
    logic [IW-1:0]   sel_s;
    logic            pop_s;
    logic            space_s;
    logic            push_s;
    logic [NB-1:0]   clear_s;
    logic [NB-1:0]   drop_s;
    logic [NB-1:0]   pending_nxt_s;
    logic [4:0]      drop_num_s;
    logic [7:0]      drop_nxt_s;
    logic [7:0]      push_byte_s;

    // Command byte per pending-bit index: even bits are rises, odd bits are falls.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            cmd_s[b] = 8'h00;
        end
        for (int i = 0; i < N_CH; i++) begin
            cmd_s[2*i]   = RISE_CMD[8*i +: 8];
            cmd_s[2*i+1] = FALL_CMD[8*i +: 8];
        end
    end

    // Edge detection on the synchronized levels, qualified into recordable events.
    always_comb begin
        armed_s = (sup_cnt_r == 2'd0);
        edge_s  = '0;
        event_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            edge_s[2*i]   = s2_r[i] & ~s3_r[i];
            edge_s[2*i+1] = ~s2_r[i] & s3_r[i];
        end
        for (int b = 0; b < NB; b++) begin
            event_s[b] = edge_s[b] & armed_s & enable & (cmd_s[b] != 8'h00) & ~flush;
        end
    end

    // Fixed-priority arbiter: lowest set pending index wins.
    always_comb begin
        grant_s = '0;
        found_s = 1'b0;
        sel_s   = '0;
        for (int b = 0; b < NB; b++) begin
            grant_s[b] = pending_r[b] & ~found_s;
            sel_s      = grant_s[b] ? IW'(b) : sel_s;
            found_s    = found_s | pending_r[b];
        end
    end

    // Push/pop decisions; a full FIFO still accepts a push when the head leaves.
    always_comb begin
        pop_s       = tx_ready & (count_r != '0) & ~flush;
        space_s     = (count_r != CW'(DEPTH)) | pop_s;
        push_s      = found_s & space_s & ~flush;
        clear_s     = grant_s & {NB{push_s}};
        push_byte_s = cmd_s[sel_s];
    end

    // Next pending flags and the number of events coalesced this cycle.
    always_comb begin
        drop_s     = event_s & pending_r & ~clear_s;
        drop_num_s = 5'd0;
        for (int b = 0; b < NB; b++) begin
            drop_num_s = drop_num_s + {4'b0000, drop_s[b]};
        end
        drop_nxt_s = sat_add8(drop_cnt_r, drop_num_s);
        if (flush) begin
            pending_nxt_s = '0;
        end else begin
            pending_nxt_s = (pending_r & ~clear_s) | event_s;
        end
    end

    // Two-flop synchronizer plus history flop; flush does not disturb it.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_r <= '0;
            s2_r <= '0;
            s3_r <= '0;
        end else begin
            s1_r <= req_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Post-reset blanking so levels already present at reset are not seen as edges.
    always_ff @(posedge clock) begin
        if (reset) begin
            sup_cnt_r <= 2'd3;
        end else if (sup_cnt_r != 2'd0) begin
            sup_cnt_r <= sup_cnt_r - 2'd1;
        end else begin
            sup_cnt_r <= sup_cnt_r;
        end
    end

    // Pending flags and the saturating coalesced-event counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_r  <= '0;
            drop_cnt_r <= 8'h00;
        end else begin
            pending_r  <= pending_nxt_s;
            drop_cnt_r <= drop_nxt_s;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are only visible through count-gated reads.
    always_ff @(posedge clock) begin
        if (push_s && !reset) begin
            mem_r[wr_ptr_r] <= push_byte_s;
        end
    end

    // Registered head byte for the UART, idle value 8'h00 when empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_bits_r <= 8'h00;
        end else if (flush) begin
            tx_bits_r <= 8'h00;
        end else if (count_r != '0) begin
            tx_bits_r <= mem_r[rd_ptr_r];
        end else begin
            tx_bits_r <= 8'h00;
        end
    end

    assign tx_bits    = tx_bits_r;
    assign fifo_count = count_r;
    assign pending    = pending_r;
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_cmd_tx_queue.sv
// Testbench for cmd_tx_queue: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_cmd_tx_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance 0: default parameters
    logic       rst0, en0, fl0, rdy0;
    logic [3:0] req0;
    logic [7:0] tx0, pend0, drop0;
    logic [3:0] cnt0;

    // Instance 1: two channels, ch1 rise = 8'h21
    logic       rst1, en1, fl1, rdy1;
    logic [1:0] req1;
    logic [7:0] tx1, drop1;
    logic [3:0] cnt1, pend1;

    // Instance 2: depth 2, four nonzero commands
    localparam logic [31:0] D2_RISE = {8'h00, 8'h00, 8'h21, 8'h05};
    localparam logic [31:0] D2_FALL = {8'h00, 8'h00, 8'h22, 8'h09};
    localparam int          D2_DEPTH = 2;
    logic       rst2, en2, fl2, rdy2;
    logic [3:0] req2;
    logic [7:0] tx2, pend2, drop2;
    logic [1:0] cnt2;

    cmd_tx_queue dut0 (
        .clock(clk), .reset(rst0), .req_in(req0), .enable(en0), .flush(fl0),
        .tx_bits(tx0), .tx_ready(rdy0), .fifo_count(cnt0), .pending(pend0), .drop_cnt(drop0)
    );

    cmd_tx_queue #(
        .N_CH(2), .DEPTH(8),
        .RISE_CMD({8'h21, 8'h05}), .FALL_CMD({8'h00, 8'h09})
    ) dut1 (
        .clock(clk), .reset(rst1), .req_in(req1), .enable(en1), .flush(fl1),
        .tx_bits(tx1), .tx_ready(rdy1), .fifo_count(cnt1), .pending(pend1), .drop_cnt(drop1)
    );

    cmd_tx_queue #(
        .N_CH(4), .DEPTH(D2_DEPTH), .RISE_CMD(D2_RISE), .FALL_CMD(D2_FALL)
    ) dut2 (
        .clock(clk), .reset(rst2), .req_in(req2), .enable(en2), .flush(fl2),
        .tx_bits(tx2), .tx_ready(rdy2), .fifo_count(cnt2), .pending(pend2), .drop_cnt(drop2)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       en;
        logic       fl;
        logic       rdy;
        logic [7:0] e_tx;
        logic [3:0] e_cnt;
        logic [7:0] e_pend;
        logic [7:0] e_drop;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] cur_tx(input int which);
        return (which == 1) ? tx1 : tx2;
    endfunction

    task automatic set_rdy(input int which, input logic v);
        if (which == 1) rdy1 = v;
        else            rdy2 = v;
    endtask

    // Wait (bounded) for a byte on tx_bits, check it, then pulse tx_ready once.
    task automatic serve(input int which, input logic [7:0] exp, input string nm);
        int waited;
        waited = 0;
        while (cur_tx(which) == 8'h00 && waited < 60) begin
            tick(1);
            waited++;
        end
        chk(nm, 32'(cur_tx(which)), 32'(exp));
        set_rdy(which, 1'b1);
        tick(1);
        set_rdy(which, 1'b0);
        tick(1);
    endtask

    // ---------------- reference model for instance 2 ----------------
    logic [7:0] mq[$];
    logic [7:0] m_pend;
    int         m_drop;
    logic [7:0] m_tx;
    logic [3:0] hist[$];
    int         m_post;

    function automatic logic [7:0] cmd_of(input int b);
        logic [31:0] tbl;
        tbl = (b % 2 == 0) ? D2_RISE : D2_FALL;
        return tbl[8*(b/2) +: 8];
    endfunction

    // One clock edge of the model: events come from the input two and three
    // samples back; edges are ignored during the first three edges after reset.
    task automatic model_step(input logic rst, input logic [3:0] rq, input logic en,
                              input logic fl, input logic rdy);
        logic [3:0] old_v, new_v;
        logic [7:0] evb;
        int         sel;
        bit         pop;
        if (rst) begin
            mq.delete();
            m_pend = 8'h00;
            m_drop = 0;
            m_tx   = 8'h00;
            hist.delete();
            repeat (3) hist.push_back(4'h0);
            m_post = 0;
        end else begin
            if (m_post < 10) m_post++;
            m_tx  = (fl || mq.size() == 0) ? 8'h00 : mq[0];
            old_v = hist[0];
            new_v = hist[1];
            evb   = 8'h00;
            for (int ch = 0; ch < 4; ch++) begin
                if (m_post > 3 && en && !fl) begin
                    if (new_v[ch] && !old_v[ch] && cmd_of(2*ch) != 8'h00) evb[2*ch] = 1'b1;
                    if (!new_v[ch] && old_v[ch] && cmd_of(2*ch+1) != 8'h00) evb[2*ch+1] = 1'b1;
                end
            end
            if (fl) begin
                mq.delete();
                m_pend = 8'h00;
            end else begin
                pop = rdy && (mq.size() > 0);
                sel = -1;
                for (int b = 0; b < 8; b++) begin
                    if (m_pend[b] && sel < 0) sel = b;
                end
                if (pop) void'(mq.pop_front());
                if (sel >= 0 && mq.size() < D2_DEPTH) begin
                    mq.push_back(cmd_of(sel));
                    m_pend[sel] = 1'b0;
                end
                for (int b = 0; b < 8; b++) begin
                    if (evb[b]) begin
                        if (m_pend[b] && m_drop < 255) m_drop++;
                        m_pend[b] = 1'b1;
                    end
                end
            end
            hist.push_back(rq);
            void'(hist.pop_front());
        end
    endtask

    initial begin
        rst0 = 1'b1; req0 = 4'h0; en0 = 1'b1; fl0 = 1'b0; rdy0 = 1'b0;
        rst1 = 1'b1; req1 = 2'b00; en1 = 1'b1; fl1 = 1'b0; rdy1 = 1'b0;
        rst2 = 1'b1; req2 = 4'h0; en2 = 1'b1; fl2 = 1'b0; rdy2 = 1'b0;

        //            rst   req   en    fl    rdy   tx     cnt   pend   drop
        vecs[0]  = '{1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00};
        vecs[6]  = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h01, 8'h00};
        vecs[8]  = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 8'h05, 4'd1, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 8'h05, 4'd0, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 8'h00, 8'h00};
        vecs[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00};
        vecs[13] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 8'h00};
        vecs[14] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h02, 8'h00};
        vecs[15] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 8'h00, 8'h00};
        vecs[16] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h09, 4'd1, 8'h00, 8'h00};

        @(negedge clk);
        // Table: reset, rise -> 8'h05 after 4 edges, pop, ignored pop, fall -> 8'h09
        for (int i = 0; i < 17; i++) begin
            rst0 = vecs[i].rst; req0 = vecs[i].req; en0 = vecs[i].en;
            fl0  = vecs[i].fl;  rdy0 = vecs[i].rdy;
            tick(1);
            chk($sformatf("vec%0d_tx", i),   32'(tx0),   32'(vecs[i].e_tx));
            chk($sformatf("vec%0d_cnt", i),  32'(cnt0),  32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_pend", i), 32'(pend0), 32'(vecs[i].e_pend));
            chk($sformatf("vec%0d_drop", i), 32'(drop0), 32'(vecs[i].e_drop));
        end

        // Hold tx_ready low: byte must stay presented
        rdy0 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            chk("hold_tx", 32'(tx0), 32'h09);
            chk("hold_cnt", 32'(cnt0), 32'd1);
        end

        // Level high through reset release must not produce an event
        rst0 = 1'b1; req0 = 4'h1;
        tick(2);
        rst0 = 1'b0;
        tick(10);
        chk("rstlvl_tx", 32'(tx0), 32'h00);
        chk("rstlvl_pend", 32'(pend0), 32'h00);
        chk("rstlvl_cnt", 32'(cnt0), 32'd0);

        // Queue three bytes, then flush
        req0 = 4'h0; tick(5);
        req0 = 4'h1; tick(5);
        req0 = 4'h0; tick(5);
        chk("preflush_cnt", 32'(cnt0), 32'd3);
        chk("preflush_tx", 32'(tx0), 32'h09);
        fl0 = 1'b1;
        tick(1);
        fl0 = 1'b0;
        chk("flush_cnt", 32'(cnt0), 32'd0);
        chk("flush_tx", 32'(tx0), 32'h00);
        chk("flush_pend", 32'(pend0), 32'h00);
        chk("flush_drop", 32'(drop0), 32'h00);
        tick(1);
        chk("postflush_tx", 32'(tx0), 32'h00);

        // Release the other two instances
        rst1 = 1'b0; rst2 = 1'b0;
        tick(5);

        // Two-channel simultaneous rise: 8'h05 then 8'h21 on consecutive pushes
        req1 = 2'b11;
        tick(3);
        chk("dual_pend_k2", 32'(pend1), 32'h5);
        tick(1);
        chk("dual_cnt_k3", 32'(cnt1), 32'd1);
        chk("dual_pend_k3", 32'(pend1), 32'h4);
        tick(1);
        chk("dual_cnt_k4", 32'(cnt1), 32'd2);
        chk("dual_pend_k4", 32'(pend1), 32'h0);
        serve(1, 8'h05, "dual_first");
        serve(1, 8'h21, "dual_second");
        tick(2);
        chk("dual_empty", 32'(cnt1), 32'd0);

        // Depth 2: four events, two held pending, delivered in arbiter order
        req2 = 4'b0011;
        tick(3);
        chk("d2_pend_rise", 32'(pend2), 32'h05);
        tick(1);
        chk("d2_cnt1", 32'(cnt2), 32'd1);
        chk("d2_pend1", 32'(pend2), 32'h04);
        tick(1);
        chk("d2_cnt2", 32'(cnt2), 32'd2);
        req2 = 4'b0000;
        tick(4);
        chk("d2_full_cnt", 32'(cnt2), 32'd2);
        chk("d2_full_pend", 32'(pend2), 32'h0A);
        tick(10);
        chk("d2_held_pend", 32'(pend2), 32'h0A);
        serve(2, 8'h05, "d2_b0");
        serve(2, 8'h21, "d2_b1");
        serve(2, 8'h09, "d2_b2");
        serve(2, 8'h22, "d2_b3");
        tick(3);
        chk("d2_drain_cnt", 32'(cnt2), 32'd0);
        chk("d2_drain_pend", 32'(pend2), 32'h00);

        // Full FIFO, channel 0 rises twice before service: one drop, one 8'h05
        req2 = 4'b0010; tick(5);
        req2 = 4'b0000; tick(5);
        chk("drop_fill_cnt", 32'(cnt2), 32'd2);
        req2 = 4'b0001; tick(5);
        req2 = 4'b0000; tick(5);
        req2 = 4'b0001; tick(5);
        chk("drop_cnt_one", 32'(drop2), 32'd1);
        chk("drop_pend", 32'(pend2), 32'h03);
        chk("drop_full", 32'(cnt2), 32'd2);
        serve(2, 8'h21, "drop_b0");
        serve(2, 8'h22, "drop_b1");
        serve(2, 8'h05, "drop_b2");
        serve(2, 8'h09, "drop_b3");
        tick(10);
        chk("drop_end_cnt", 32'(cnt2), 32'd0);
        chk("drop_end_tx", 32'(tx2), 32'h00);
        chk("drop_end_pend", 32'(pend2), 32'h00);
        chk("drop_end_drop", 32'(drop2), 32'd1);

        // Randomized run against the reference model
        for (int c = 0; c < 1600; c++) begin
            rst2 = (c < 2) || ($urandom_range(0, 399) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) req2[b] = ~req2[b];
            end
            en2  = ($urandom_range(0, 9) != 0);
            fl2  = ($urandom_range(0, 79) == 0);
            rdy2 = ($urandom_range(0, 99) < (((c / 200) % 2 == 1) ? 50 : 10));
            @(posedge clk);
            model_step(rst2, req2, en2, fl2, rdy2);
            @(negedge clk);
            chk("rnd_tx", 32'(tx2), 32'(m_tx));
            chk("rnd_cnt", 32'(cnt2), 32'(mq.size()));
            chk("rnd_pend", 32'(pend2), 32'(m_pend));
            chk("rnd_drop", 32'(drop2), 32'(m_drop));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
